sc_grid_monitor: RTL
====================

Name: sc_grid_monitor

Overview:
- Producer side of the grid_state interface consumed by the charging FSM.
- Classifies grid-voltage magnitude samples from the ADC front end into NORMAL / UNSTABLE / CRITICAL.
- Applies asymmetric debounce: fast degrade, slow recovery.
- Forces CRITICAL when the sample stream stops. Drives grid_state onto the sc_interface_if bus.

Parameters:
- ADC_W, 12, sample width (unsigned code).
- NORM_LO, 1800, lowest code classified NORMAL.
- NORM_HI, 2300, highest code classified NORMAL.
- CRIT_LO, 1500, codes below this are CRITICAL.
- CRIT_HI, 2600, codes above this are CRITICAL.
- DEG_CNT, 4, consecutive samples needed for NORMAL->UNSTABLE.
- CRIT_CNT, 2, consecutive samples needed for any ->CRITICAL.
- RECOV_CNT, 16, consecutive samples needed for any improvement; also the warm-up length for state_valid.
- TIMEOUT_CYC, 1000, clk cycles without sample_valid before a forced CRITICAL.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- sample_valid, in, 1: sample_data is valid this cycle.
- sample_data, in, ADC_W: grid voltage magnitude code.
- grid_state, out, 2: debounced grid_state_t.
- state_valid, out, 1: grid_state is qualified (warm-up complete).
- critical_pulse, out, 1: one-cycle pulse on entry to CRITICAL.
- sample_timeout, out, 1: sample stream lost.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset. All state updates on posedge clk.
- Reset values: grid_state=GRID_UNSTABLE, state_valid=0, critical_pulse=0, sample_timeout=0. All counters 0. cand_zone=GRID_UNSTABLE.
- Reset mid-operation clears everything to the values above in the same edge. It has priority over every other event.
- Zone classification (combinational on sample_data, unsigned compare):
  - z=CRITICAL if code<CRIT_LO or code>CRIT_HI.
  - else z=NORMAL if NORM_LO<=code<=NORM_HI.
  - else z=UNSTABLE.
- Debounce, evaluated only on edges with sample_valid=1:
  - z==grid_state: clear cand_cnt.
  - z!=cand_zone: cand_zone<=z, cand_cnt<=1.
  - otherwise: cand_cnt increments, saturating.
  - Threshold T depends on the target: z==CRITICAL uses CRIT_CNT; NORMAL->UNSTABLE uses DEG_CNT; any improvement (CRIT->UNST, CRIT->NORM, UNST->NORM) uses RECOV_CNT.
  - When the post-update count reaches T: commit grid_state<=z on that edge and clear cand_cnt. The new state is visible the cycle after the T-th qualifying valid.
  - T=1 commits on the first sample.
- Warm-up: a saturating accepted-sample counter. state_valid<=1 on the edge where it reaches RECOV_CNT. Once set, state_valid clears only on reset or timeout.
- Watchdog:
  - wd_cnt increments every cycle without sample_valid and resets to 0 on sample_valid.
  - On reaching TIMEOUT_CYC: grid_state<=GRID_CRITICAL, sample_timeout<=1, state_valid<=0, cand_cnt<=0.
  - sample_valid on the same edge the count would reach TIMEOUT_CYC wins: no timeout, and the sample is processed normally.
  - sample_timeout clears on the next sample_valid. grid_state stays CRITICAL until normal recovery debounce completes; there is no shortcut.
- critical_pulse=1 for exactly one cycle after any edge where grid_state changes from non-CRITICAL to CRITICAL (debounce or watchdog). No pulse if already CRITICAL.
- Encoding code 2'b11 never driven.
- Counter widths are $clog2(max+1) of their limit. No wrap: all counters saturate.

Optional Feature:
- Macro: SC_GRID_STATS_EN.
- Defined: adds outputs unstable_events[15:0] and critical_events[15:0]. These are saturating counts of commits into UNSTABLE and CRITICAL respectively, watchdog entries included, reset to 0.
- Undefined: these ports and counters do not exist, and core behaviour is identical.

Decomposition:
- sc_types_pkg: existing grid_state_t (GRID_NORMAL=0, GRID_UNSTABLE=1, GRID_CRITICAL=2) plus new localparam-free helper function sc_grid_classify(code, limits) returning grid_state_t.
- Sub-module sc_sample_watchdog (params TIMEOUT_CYC): inputs clk, reset, sample_valid; output timeout_hit (single-cycle strobe) and sample_timeout level.

Test Plan:
- Reset, then 16 valid samples of 2000 -> state_valid rises after 16th; grid_state goes UNSTABLE->NORMAL one cycle after 16th valid.
- From NORMAL, 3 samples of 1700 then 1 of 2000 -> no change; 4 consecutive 1700 -> UNSTABLE after 4th, critical_pulse stays 0.
- From NORMAL, 2 samples of 2700 -> CRITICAL after 2nd; critical_pulse high exactly 1 cycle; a 3rd 2700 gives no pulse.
- From NORMAL, alternating 1700/2700 for 20 samples -> grid_state stays NORMAL (candidate restarts each sample).
- From NORMAL, stop sample_valid for 1000 cycles -> CRITICAL, sample_timeout=1, state_valid=0, pulse; with sample at cycle 1000 instead -> no timeout; then 16 samples of 2000 -> NORMAL.
- reset asserted one cycle during a 3-of-4 degrade run -> all outputs at reset values next cycle; candidate count restarts.

Source files
------------

// File: rtl/sc_types_pkg.sv
// Shared grid-monitor types: the grid_state_t encoding seen by the charging FSM,
// the classification limits record, and the zone classification helper.
package sc_types_pkg;

    typedef enum logic [1:0] {
        GRID_NORMAL   = 2'd0,
        GRID_UNSTABLE = 2'd1,
        GRID_CRITICAL = 2'd2
    } grid_state_t;

    // Zone boundaries. Codes are carried at 16 bits so one helper serves any ADC width up to 16.
    typedef struct packed {
        logic [15:0] crit_lo;
        logic [15:0] norm_lo;
        logic [15:0] norm_hi;
        logic [15:0] crit_hi;
    } grid_limits_t;

    // Unsigned zone classification. Out-of-band codes are critical; the normal band sits inside the unstable band.
    function automatic grid_state_t sc_grid_classify(input logic [15:0] code, input grid_limits_t limits);
        grid_state_t zone;
        if ((code < limits.crit_lo) || (code > limits.crit_hi)) begin
            zone = GRID_CRITICAL;
        end else if ((code >= limits.norm_lo) && (code <= limits.norm_hi)) begin
            zone = GRID_NORMAL;
        end else begin
            zone = GRID_UNSTABLE;
        end
        return zone;
    endfunction

endpackage

// File: rtl/sc_sample_watchdog.sv
// Sample-stream watchdog: counts idle cycles, strobes timeout_hit on the edge the
// idle count reaches TIMEOUT_CYC, and holds sample_timeout until the next sample.
module sc_sample_watchdog #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_valid,
    output logic timeout_hit,
    output logic sample_timeout
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_cnt;

    // A sample on the would-be timeout edge suppresses the strobe; once saturated the strobe cannot repeat.
    assign timeout_hit = !sample_valid && (wd_cnt == WD_LAST);

    // Idle counter saturates at the limit; the sticky timeout flag drops as soon as samples resume.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt         <= '0;
            sample_timeout <= 1'b0;
        end else if (sample_valid) begin
            wd_cnt         <= '0;
            sample_timeout <= 1'b0;
        end else begin
            if (wd_cnt != WD_LIMIT) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (timeout_hit) begin
                sample_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_grid_monitor.sv
// Grid monitor: classifies ADC voltage samples, debounces the zone (fast degrade,
// slow recovery), forces CRITICAL when samples stop, and publishes grid_state.
// Optional event counters are built when SC_GRID_STATS_EN is defined.
module sc_grid_monitor
    import sc_types_pkg::*;
#(
    parameter int ADC_W       = 12,
    parameter int NORM_LO     = 1800,
    parameter int NORM_HI     = 2300,
    parameter int CRIT_LO     = 1500,
    parameter int CRIT_HI     = 2600,
    parameter int DEG_CNT     = 4,
    parameter int CRIT_CNT    = 2,
    parameter int RECOV_CNT   = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] sample_data,
    output logic [1:0]       grid_state,
    output logic             state_valid,
    output logic             critical_pulse,
`ifdef SC_GRID_STATS_EN
    output logic [15:0]      unstable_events,
    output logic [15:0]      critical_events,
`endif
    output logic             sample_timeout
);

    localparam int CAND_MAX = (RECOV_CNT > DEG_CNT) ?
                              ((RECOV_CNT > CRIT_CNT) ? RECOV_CNT : CRIT_CNT) :
                              ((DEG_CNT > CRIT_CNT) ? DEG_CNT : CRIT_CNT);
    localparam int CAND_W = $clog2(CAND_MAX + 1);
    localparam int ACC_W  = $clog2(RECOV_CNT + 1);

    localparam logic [CAND_W-1:0] CAND_SAT = CAND_W'(CAND_MAX);
    localparam logic [CAND_W-1:0] DEG_T    = CAND_W'(DEG_CNT);
    localparam logic [CAND_W-1:0] CRIT_T   = CAND_W'(CRIT_CNT);
    localparam logic [CAND_W-1:0] RECOV_T  = CAND_W'(RECOV_CNT);
    localparam logic [ACC_W-1:0]  ACC_FULL = ACC_W'(RECOV_CNT);

    localparam grid_limits_t LIMITS = '{
        crit_lo: 16'(CRIT_LO),
        norm_lo: 16'(NORM_LO),
        norm_hi: 16'(NORM_HI),
        crit_hi: 16'(CRIT_HI)
    };

    grid_state_t       gs_q, gs_d;
    grid_state_t       cand_zone_q, cand_zone_d;
    grid_state_t       zone;
    logic [CAND_W-1:0] cand_cnt_q, cand_cnt_d;
    logic [CAND_W-1:0] threshold;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              valid_q, valid_d;
    logic              pulse_q, pulse_d;
    logic              timeout_hit;

    sc_sample_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .timeout_hit    (timeout_hit),
        .sample_timeout (sample_timeout)
    );

    assign zone = sc_grid_classify(16'(sample_data), LIMITS);

    assign grid_state     = gs_q;
    assign state_valid    = valid_q;
    assign critical_pulse = pulse_q;

    // Debounce target threshold: any move into CRITICAL is fast, NORMAL->UNSTABLE is medium, every improvement is slow.
    always_comb begin
        threshold = RECOV_T;
        if (zone == GRID_CRITICAL) begin
            threshold = CRIT_T;
        end else if ((zone == GRID_UNSTABLE) && (gs_q == GRID_NORMAL)) begin
            threshold = DEG_T;
        end
    end

    // Next-state logic: watchdog expiry overrides the sample path; otherwise each valid sample advances debounce and warm-up.
    always_comb begin
        gs_d        = gs_q;
        cand_zone_d = cand_zone_q;
        cand_cnt_d  = cand_cnt_q;
        acc_d       = acc_q;
        valid_d     = valid_q;
        pulse_d     = 1'b0;

        if (timeout_hit) begin
            // Warm-up restarts so state_valid requalifies only after a fresh run of samples.
            gs_d       = GRID_CRITICAL;
            cand_cnt_d = '0;
            valid_d    = 1'b0;
            acc_d      = '0;
        end else if (sample_valid) begin
            if (acc_q != ACC_FULL) begin
                acc_d = acc_q + ACC_W'(1);
                if (acc_d == ACC_FULL) begin
                    valid_d = 1'b1;
                end
            end

            if (zone == gs_q) begin
                cand_cnt_d = '0;
            end else begin
                if (zone != cand_zone_q) begin
                    cand_zone_d = zone;
                    cand_cnt_d  = CAND_W'(1);
                end else if (cand_cnt_q != CAND_SAT) begin
                    cand_cnt_d = cand_cnt_q + CAND_W'(1);
                end
                if (cand_cnt_d >= threshold) begin
                    gs_d       = zone;
                    cand_cnt_d = '0;
                end
            end
        end

        if ((gs_d == GRID_CRITICAL) && (gs_q != GRID_CRITICAL)) begin
            pulse_d = 1'b1;
        end
    end

    // State register; reset wins over every sample or watchdog event on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            gs_q        <= GRID_UNSTABLE;
            cand_zone_q <= GRID_UNSTABLE;
            cand_cnt_q  <= '0;
            acc_q       <= '0;
            valid_q     <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            gs_q        <= gs_d;
            cand_zone_q <= cand_zone_d;
            cand_cnt_q  <= cand_cnt_d;
            acc_q       <= acc_d;
            valid_q     <= valid_d;
            pulse_q     <= pulse_d;
        end
    end

`ifdef SC_GRID_STATS_EN
    // Saturating counts of entries into UNSTABLE and CRITICAL, watchdog entries included.
    always_ff @(posedge clk) begin
        if (reset) begin
            unstable_events <= '0;
            critical_events <= '0;
        end else begin
            if ((gs_d == GRID_UNSTABLE) && (gs_q != GRID_UNSTABLE) && (unstable_events != 16'hFFFF)) begin
                unstable_events <= unstable_events + 16'd1;
            end
            if ((gs_d == GRID_CRITICAL) && (gs_q != GRID_CRITICAL) && (critical_events != 16'hFFFF)) begin
                critical_events <= critical_events + 16'd1;
            end
        end
    end
`endif

endmodule
